// File: rtl/spi_controller.sv
// spi_controller: 16-bit mode-0 SPI write master with a registered SCLK/CS/COPI
// and a minimum CS-high gap after every frame.
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_cs
);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_END = 8'(CS_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] frame_q, frame_d;
  logic        active_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          frame_d = {rw, addr, wdata};
          bit_d   = 4'd15;
          state_d = LOW;
        end
      end
      LOW: if (cnt_q == DIV_END) begin
        cnt_d   = '0;
        state_d = HIGH;
      end
      HIGH: if (cnt_q == DIV_END) begin
        cnt_d   = '0;
        state_d = (bit_q == 4'd0) ? HOLD : LOW;
        bit_d   = (bit_q == 4'd0) ? bit_q : bit_q - 4'd1;
      end
      HOLD: if (cnt_q == DIV_END) begin
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: if (cnt_q == GAP_END) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Pins are registered from the next state so they change together with it.
  assign active_d = (state_d == LOW) || (state_d == HIGH) || (state_d == HOLD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_copi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      spi_cs   <= !active_d;
      spi_sclk <= state_d == HIGH;
      spi_copi <= active_d & frame_d[bit_d];
      busy     <= state_d != IDLE;
      done     <= (state_q == GAP) && (state_d == IDLE);
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: random and directed frames on a default and a fast
// instance, checked against an SPI-slave style model of the bus.
module tb_spi_controller;
  logic clk = 0, rst_n = 0, rw = 0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic start_w [2];
  logic busy_w [2], done_w [2], sclk_w [2], copi_w [2], cs_w [2];
  int checks = 0, errors = 0, cyc = 0;
  int busy_cnt [2], done_cnt [2], rise_cnt [2], rise_bad [2], stab_err [2];
  int bitn [2], cs_run [2], last_gap [2], last_rise [2], period [2], frame_cnt [2];
  logic [15:0] shr [2];
  logic [15:0] frame_log [2][8];
  logic sclk_p [2], copi_p [2], cs_p [2];
  logic [7:0] regs [128];

  always #5 clk = ~clk;

  spi_controller dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_w[0]), .done(done_w[0]), .spi_sclk(sclk_w[0]), .spi_copi(copi_w[0]), .spi_cs(cs_w[0]));
  spi_controller #(.CLK_DIV(2), .CS_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_w[1]), .done(done_w[1]), .spi_sclk(sclk_w[1]), .spi_copi(copi_w[1]), .spi_cs(cs_w[1]));

  // Bus observer: behaves like a mode-0 slave that latches writes on CS rise.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (busy_w[i]) busy_cnt[i]++;
      if (done_w[i]) done_cnt[i]++;
      if (sclk_w[i] && !sclk_p[i]) begin
        rise_cnt[i]++;
        if (cs_w[i]) rise_bad[i]++;
        shr[i] = {shr[i][14:0], copi_w[i]};
        bitn[i]++;
        if (last_rise[i] != 0) period[i] = cyc - last_rise[i];
        last_rise[i] = cyc;
      end else if (sclk_w[i] && copi_w[i] != copi_p[i]) stab_err[i]++;
      if (!cs_w[i] && cs_p[i]) begin
        last_gap[i] = cs_run[i];
        bitn[i] = 0;
      end
      cs_run[i] = cs_w[i] ? cs_run[i] + 1 : 0;
      if (cs_w[i] && !cs_p[i] && bitn[i] == 16) begin
        frame_log[i][frame_cnt[i] % 8] = shr[i];
        frame_cnt[i]++;
        if (i == 0 && shr[i][15]) regs[shr[i][14:8]] = shr[i][7:0];
      end
      sclk_p[i] = sclk_w[i];
      copi_p[i] = copi_w[i];
      cs_p[i] = cs_w[i];
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear(int i);
    busy_cnt[i] = 0; done_cnt[i] = 0; rise_cnt[i] = 0; rise_bad[i] = 0; stab_err[i] = 0;
    last_rise[i] = 0; period[i] = 0; frame_cnt[i] = 0; last_gap[i] = 0;
  endtask

  task automatic go(int i, logic [15:0] f);
    {rw, addr, wdata} = f;
    start_w[i] = 1;
    @(posedge clk);
    #1 start_w[i] = 0;
  endtask

  task automatic wait_done(int i, int n);
    for (int k = 0; k < 3000 && done_cnt[i] < n; k++) begin
      @(negedge clk);
      #1;
    end
    check("done_timeout", 32'(done_cnt[i] >= n), 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic frame_test(int i, logic [15:0] f, int div, int gap);
    clear(i);
    go(i, f);
    wait_done(i, 1);
    check("frame", 32'(frame_log[i][0]), 32'(f));
    check("busy_len", busy_cnt[i], 33 * div + gap);
    check("done_cnt", done_cnt[i], 1);
    check("rises", rise_cnt[i], 16);
    check("rise_cs_high", rise_bad[i], 0);
    check("copi_stable", stab_err[i], 0);
  endtask

  initial begin
    logic [15:0] f;
    start_w[0] = 0; start_w[1] = 0;
    for (int i = 0; i < 2; i++) begin
      sclk_p[i] = 0; copi_p[i] = 0; cs_p[i] = 1; cs_run[i] = 0; bitn[i] = 0; shr[i] = '0;
      clear(i);
    end
    for (int k = 0; k < 128; k++) regs[k] = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check("reset_pins", {28'd0, cs_w[i], sclk_w[i], copi_w[i], busy_w[i] | done_w[i]}, 32'b1000);
    rst_n = 1;

    frame_test(0, 16'h8480, 4, 4);
    for (int n = 0; n < 4; n++) frame_test(0, 16'($urandom), 4, 4);

    // Starts during a frame are dropped.
    clear(0);
    go(0, 16'h9234);
    repeat (3) @(posedge clk);
    #1 go(0, 16'h1111);
    repeat (93) @(posedge clk);
    #1 go(0, 16'h2222);
    wait_done(0, 1);
    repeat (200) @(negedge clk);
    #1;
    check("ignore_done", done_cnt[0], 1);
    check("ignore_frames", frame_cnt[0], 1);
    check("ignore_data", 32'(frame_log[0][0]), 32'h9234);

    // Reset while SCLK is high for bit 9.
    clear(0);
    go(0, 16'hC3A5);
    for (int k = 0; k < 3000 && !(rise_cnt[0] == 7 && sclk_w[0]); k++) begin
      @(negedge clk);
      #1;
    end
    check("bit9_reached", rise_cnt[0], 7);
    rst_n = 0;
    #1;
    check("rst_cs", 32'(cs_w[0]), 1);
    check("rst_sclk", 32'(sclk_w[0]), 0);
    check("rst_busy", 32'(busy_w[0]), 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (300) @(negedge clk);
    #1;
    check("rst_no_done", done_cnt[0], 0);
    check("rst_no_frame", frame_cnt[0], 0);
    frame_test(0, 16'h5A0F, 4, 4);

    // Start held high: back-to-back frames.
    clear(0);
    {rw, addr, wdata} = 16'h80F0;
    start_w[0] = 1;
    @(posedge clk);
    #1 {rw, addr, wdata} = 16'h81AA;
    for (int k = 0; k < 3000 && done_cnt[0] < 2; k++) begin
      @(negedge clk);
      #1;
    end
    start_w[0] = 0;
    repeat (300) @(negedge clk);
    #1;
    check("b2b_done", done_cnt[0], 2);
    check("b2b_gap", last_gap[0], 5);
    check("b2b_f0", 32'(frame_log[0][0]), 32'h80F0);
    check("b2b_f1", 32'(frame_log[0][1]), 32'h81AA);

    // Loopback writes into the modelled register file.
    for (int k = 0; k < 128; k++) regs[k] = '0;
    frame_test(0, {1'b1, 7'h00, 8'hF0}, 4, 4);
    frame_test(0, {1'b1, 7'h04, 8'h40}, 4, 4);
    frame_test(0, {1'b0, 7'h01, 8'hFF}, 4, 4);
    check("reg_00", 32'(regs[0]), 32'hF0);
    check("reg_04", 32'(regs[4]), 32'h40);
    check("reg_01", 32'(regs[1]), 32'h00);

    // Fast instance.
    for (int n = 0; n < 3; n++) begin
      f = 16'($urandom);
      frame_test(1, f, 2, 1);
      check("fast_period", period[1], 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, sets SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_GAP, default 4, sets minimum CS-high idle cycles after each frame; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a frame; sampled only when busy=0.
REQ-006 rw  input  1  frame bit 15; 1=write.
REQ-007 addr  input  7  register address, frame bits 14:8.
REQ-008 wdata  input  8  data byte, frame bits 7:0.
REQ-009 busy  output  1  high while a frame is in progress, including the CS gap.
REQ-010 done  output  1  one-cycle pulse at frame completion.
REQ-011 spi_sclk  output  1  SPI clock, mode 0, idle low.
REQ-012 spi_copi  output  1  serial data, MSB first.
REQ-013 spi_cs  output  1  chip select, active low, idle high.

Function
REQ-014 Acceptance: start=1 with busy=0 in cycle T latches {rw,addr,wdata} as a 16-bit frame; inputs are don't-care afterward.
REQ-015 start while busy=1 SHALL be ignored, with no queueing.
REQ-016 FSM states: IDLE, LOW, HIGH, HOLD, GAP.
REQ-017 IDLE -> LOW at T+1: spi_cs=0, spi_copi=frame[15], spi_sclk=0, busy=1.
REQ-018 LOW lasts CLK_DIV cycles with spi_sclk=0, then goes to HIGH.
REQ-019 HIGH lasts CLK_DIV cycles with spi_sclk=1; spi_copi SHALL be held stable for the whole HIGH phase.
REQ-020 HIGH exit after bits 15..1: go to LOW, spi_sclk falls, and spi_copi presents the next lower bit in that same cycle.
REQ-021 HIGH exit after bit 0: go to HOLD.
REQ-022 HOLD lasts CLK_DIV cycles with spi_sclk=0 and spi_cs=0; spi_copi holds bit 0.
REQ-023 GAP lasts CS_GAP cycles with spi_cs=1, spi_sclk=0, spi_copi=0.
REQ-024 GAP then returns to IDLE.
REQ-025 Exactly 16 rising spi_sclk edges SHALL occur per frame, all while spi_cs=0.
REQ-026 busy SHALL be high for exactly 33*CLK_DIV + CS_GAP cycles (136 at defaults), from T+1 through the last GAP cycle.
REQ-027 done=1 and busy=0 in the first IDLE cycle after GAP.
REQ-028 start SHALL be accepted in the done cycle, so back-to-back frames are separated by exactly CS_GAP+1 CS-high cycles.
REQ-029 Phase and bit counters SHALL be sized for maximum parameter values with no wrap-around inside a frame.
REQ-030 All outputs SHALL be registered, with no combinational path from start to the SPI pins.

Reset
REQ-031 rst_n=0 SHALL force immediately, regardless of state: spi_cs=1, spi_sclk=0, spi_copi=0, busy=0, done=0, FSM=IDLE, frame and counters cleared.
REQ-032 Reset mid-frame SHALL abort the frame with no done pulse; the first start after release begins a full new frame.
REQ-033 After rst_n deasserts, start is accepted from the first rising clk edge.

Verification
REQ-034 Defaults; rw=1, addr=0x04, wdata=0x80 -> COPI sampled at the 16 SCLK rising edges equals 0x8480 MSB first; busy high 136 cycles; one done pulse.
REQ-035 start pulsed at cycles T+5 and T+100 during a frame -> ignored; exactly one frame and one done pulse.
REQ-036 rst_n=0 during the HIGH phase of bit 9 -> same cycle: spi_cs=1, spi_sclk=0, busy=0; no done pulse; next frame is complete and correct.
REQ-037 start held high continuously with frames 0x80F0 then 0x81AA -> two frames; CS high exactly 5 cycles between them; two done pulses.
REQ-038 Loopback into the team SPI peripheral at CLK_DIV=4; write addr 0x00 data 0xF0, then addr 0x04 data 0x40, then rw=0 addr 0x01 data 0xFF -> en_reg_out_7_0=0xF0, pwm_duty_cycle=0x40, en_reg_out_15_8 stays 0x00.
REQ-039 CLK_DIV=2, CS_GAP=1 -> busy high 67 cycles; SCLK period 4 clk; 16 rising edges.
